// File: rtl/aes_8to128_rx_pkg.sv
// Shared constants and state encoding for the 8-to-128 AES result reassembler.
package aes_8to128_rx_pkg;

  localparam int RX_NBYTES  = 16;
  localparam int RX_BLK_W   = 8 * RX_NBYTES;
  localparam int RX_TIMEOUT = 255;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/aes_rx_gap_timer.sv
// Idle-gap counter for an in-progress frame; pulses tmo_o on the idle cycle
// that brings the gap up to TIMEOUT.
module aes_rx_gap_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tmo_o
);

  localparam int            GW      = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT);
  localparam logic [GW-1:0] TMO_AT  = GW'(TIMEOUT - 1);

  logic [GW-1:0] gap_q, gap_d;

  // next gap value: clear wins, otherwise count up and saturate
  always_comb begin
    gap_d = gap_q;
    if (clr_i) begin
      gap_d = '0;
    end else if (en_i && (gap_q != GAP_MAX)) begin
      gap_d = gap_q + GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // gap register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign tmo_o = en_i & ~clr_i & (gap_q >= TMO_AT);

endmodule

// File: rtl/aes_8to128_rx.sv
// Reassembles a start-framed 8-bit byte stream into NBYTES-wide blocks and
// holds each block on a valid/ready output register with sticky error flags.
module aes_8to128_rx
  import aes_8to128_rx_pkg::*;
#(
  parameter int NBYTES    = RX_NBYTES,
  parameter int TIMEOUT   = RX_TIMEOUT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [7:0]                 byte_in_i,
  input  logic                       byte_vld_i,
  output logic [8*NBYTES-1:0]        blk_out_o,
  output logic                       blk_vld_o,
  input  logic                       blk_rdy_i,
  output logic                       busy_o,
  output logic [$clog2(NBYTES)-1:0]  byte_cnt_o,
  output logic                       err_tmo_o,
  output logic                       err_ovf_o,
  input  logic                       err_clr_i
);

  localparam int               BW       = 8 * NBYTES;
  localparam int               CNT_W    = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  rx_state_e        state_q, state_d;
  logic [BW-1:0]    sr_q, sr_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovf_q, err_ovf_d;
  logic             done_s, tmo_evt_s, ovf_evt_s;
  logic             gap_en_s, gap_tmo_s;

  function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] sr, input logic [7:0] b);
    if (MSB_FIRST) begin
      return {sr[BW-9:0], b};
    end else begin
      return {b, sr[BW-1:8]};
    end
  endfunction

  // gap only counts idle COLLECT cycles; any byte, start or leaving COLLECT clears it
  assign gap_en_s = (state_q == ST_COLLECT) & ~start_i & ~byte_vld_i;

  aes_rx_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~gap_en_s),
    .en_i  (gap_en_s),
    .tmo_o (gap_tmo_s)
  );

  // frame FSM, shift register, output register and error flags
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    vld_d     = vld_q;
    done_s    = 1'b0;
    tmo_evt_s = 1'b0;
    ovf_evt_s = 1'b0;

    if (start_i) begin
      // start in any state (re)opens a frame; a coincident byte is byte 0
      state_d = ST_COLLECT;
      if (byte_vld_i) begin
        sr_d  = shift_in('0, byte_in_i);
        cnt_d = CNT_W'(1);
      end else begin
        sr_d  = '0;
        cnt_d = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_COLLECT: begin
          if (byte_vld_i) begin
            sr_d = shift_in(sr_q, byte_in_i);
            if (cnt_q == LAST_IDX) begin
              done_s  = 1'b1;
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (gap_tmo_s) begin
            tmo_evt_s = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (done_s) begin
      if (!vld_q || blk_rdy_i) begin
        blk_d = sr_d;
        vld_d = 1'b1;
      end else begin
        ovf_evt_s = 1'b1;
      end
    end else if (vld_q && blk_rdy_i) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end

    err_tmo_d = (err_tmo_q & ~err_clr_i) | tmo_evt_s;
    err_ovf_d = (err_ovf_q & ~err_clr_i) | ovf_evt_s;
  end

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      blk_q     <= '0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      blk_q     <= blk_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign blk_out_o  = blk_q;
  assign blk_vld_o  = vld_q;
  assign busy_o     = (state_q == ST_COLLECT);
  assign byte_cnt_o = cnt_q;
  assign err_tmo_o  = err_tmo_q;
  assign err_ovf_o  = err_ovf_q;

endmodule

// File: tb/tb_aes_8to128_rx.sv
// Directed bench for aes_8to128_rx: one MSB-first and one LSB-first instance
// share the same stimulus.
module tb_aes_8to128_rx;

  localparam int TMO = 255;
  localparam logic [127:0] BLK_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_A_L = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] BLK_B   = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst, start, byte_vld, blk_rdy, err_clr;
  logic [7:0]   byte_in;
  logic [127:0] out_m, out_l;
  logic         vld_m, vld_l, busy_m, busy_l, tmo_m, tmo_l, ovf_m, ovf_l;
  logic [3:0]   cnt_m, cnt_l;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_8to128_rx #(.NBYTES(16), .TIMEOUT(TMO), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_in_i(byte_in), .byte_vld_i(byte_vld),
    .blk_out_o(out_m), .blk_vld_o(vld_m), .blk_rdy_i(blk_rdy), .busy_o(busy_m),
    .byte_cnt_o(cnt_m), .err_tmo_o(tmo_m), .err_ovf_o(ovf_m), .err_clr_i(err_clr)
  );

  aes_8to128_rx #(.NBYTES(16), .TIMEOUT(TMO), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_in_i(byte_in), .byte_vld_i(byte_vld),
    .blk_out_o(out_l), .blk_vld_o(vld_l), .blk_rdy_i(blk_rdy), .busy_o(busy_l),
    .byte_cnt_o(cnt_l), .err_tmo_o(tmo_l), .err_ovf_o(ovf_l), .err_clr_i(err_clr)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start    = 1'b0;
    byte_vld = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic put_byte(input logic [7:0] b, input logic st);
    start    = st;
    byte_vld = 1'b1;
    byte_in  = b;
    cyc();
    start    = 1'b0;
    byte_vld = 1'b0;
  endtask

  // start pulse on its own, then nb bytes of blk back-to-back
  task automatic send_frame(input logic [127:0] blk, input int nb, input logic rdy_last);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == 15 && rdy_last) blk_rdy = 1'b1;
      put_byte(blk[127-8*i -: 8], 1'b0);
    end
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; start = 1'b0; byte_vld = 1'b0; byte_in = 8'h00;
    blk_rdy = 1'b0; err_clr = 1'b0;
    idle(2);
    rst = 1'b0;

    chk("rst_vld", vld_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_cnt", cnt_m, 4'd0);
    chk("rst_out", out_m, 128'h0);
    chk("rst_err", {tmo_m, ovf_m}, 2'b00);

    // 1: basic frame, both byte orders
    blk_rdy = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_busy_start", busy_m, 1'b1);
    chk("t1_cnt_start", cnt_m, 4'd0);
    for (int i = 0; i < 16; i++) begin
      put_byte(BLK_A[127-8*i -: 8], 1'b0);
      if (i == 4) chk("t1_cnt5", cnt_m, 4'd5);
      if (i == 14) chk("t1_vld_early", vld_m, 1'b0);
    end
    chk("t1_vld", vld_m, 1'b1);
    chk("t1_out_msb", out_m, BLK_A);
    chk("t1_out_lsb", out_l, BLK_A_L);
    chk("t1_busy_end", busy_m, 1'b0);
    idle(1);
    chk("t1_vld_drop", vld_m, 1'b0);
    chk("t1_cnt_end", cnt_m, 4'd0);

    // 2: byte 0 with start, 1-3 idle cycles between later bytes
    busy_cnt = 0;
    put_byte(BLK_A[127:120], 1'b1);
    if (busy_m) busy_cnt++;
    for (int i = 1; i < 16; i++) begin
      for (int g = 0; g < (i % 3) + 1; g++) begin
        idle(1);
        if (busy_m) busy_cnt++;
      end
      put_byte(BLK_A[127-8*i -: 8], 1'b0);
      if (busy_m) busy_cnt++;
    end
    chk("t2_out", out_m, BLK_A);
    chk("t2_vld", vld_m, 1'b1);
    chk("t2_tmo", tmo_m, 1'b0);
    chk("t2_busy_cycles", 128'(busy_cnt), 128'd45);
    idle(1);

    // 3: gap timeout after 8 bytes, checked one cycle either side of the limit
    send_frame(BLK_B, 8, 1'b0);
    chk("t3_cnt8", cnt_m, 4'd8);
    idle(TMO - 1);
    chk("t3_tmo_before", tmo_m, 1'b0);
    chk("t3_busy_before", busy_m, 1'b1);
    idle(1);
    chk("t3_tmo", tmo_m, 1'b1);
    chk("t3_busy", busy_m, 1'b0);
    chk("t3_cnt", cnt_m, 4'd0);
    chk("t3_vld", vld_m, 1'b0);
    send_frame(BLK_B, 16, 1'b0);
    chk("t3_next_out", out_m, BLK_B);
    chk("t3_tmo_sticky", tmo_m, 1'b1);
    idle(1);

    // 4: overrun with output held, then reload on the accept cycle
    blk_rdy = 1'b0;
    send_frame(BLK_A, 16, 1'b0);
    chk("t4_f1_vld", vld_m, 1'b1);
    chk("t4_f1_out", out_m, BLK_A);
    chk("t4_ovf_pre", ovf_m, 1'b0);
    send_frame(BLK_B, 16, 1'b0);
    chk("t4_hold_out", out_m, BLK_A);
    chk("t4_hold_vld", vld_m, 1'b1);
    chk("t4_ovf", ovf_m, 1'b1);
    send_frame(BLK_B, 16, 1'b1);
    chk("t4_reload_out", out_m, BLK_B);
    chk("t4_reload_vld", vld_m, 1'b1);
    idle(1);
    chk("t4_vld_drop", vld_m, 1'b0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("t4_clr", {tmo_m, ovf_m}, 2'b00);

    // 5: restart mid-frame; only frame B' (= A here) survives
    send_frame(BLK_B, 5, 1'b0);
    chk("t5_cnt5", cnt_m, 4'd5);
    send_frame(BLK_A, 16, 1'b0);
    chk("t5_out_msb", out_m, BLK_A);
    chk("t5_out_lsb", out_l, BLK_A_L);
    chk("t5_err", {tmo_m, ovf_m}, 2'b00);
    idle(1);

    // 6: reset mid-frame
    send_frame(BLK_B, 10, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_out", out_m, 128'h0);
    chk("t6_state", {vld_m, busy_m, cnt_m}, 6'd0);
    for (int i = 10; i < 16; i++) put_byte(BLK_B[127-8*i -: 8], 1'b0);
    chk("t6_no_vld", vld_m, 1'b0);
    send_frame(BLK_B, 16, 1'b0);
    chk("t6_new_vld", vld_m, 1'b1);
    chk("t6_new_out", out_m, BLK_B);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
